pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, stall and forwarding controller for the in-order MIPS pipeline. It replaces the fixed three-stage hazard detection and forwarding pair with a unit that handles configurable pipeline depth, load-result latency and variable-latency memory. It tracks every in-flight destination register in an internal shadow pipeline. From that state it drives PC/IF-ID hold, ID/EX bubble insertion, IF flush, whole-pipe freeze on memory wait, and registered forwarding selects for the instruction in EXE.

## Interface
Parameters:
- REG_W, 5: register index width.
- DEPTH, 3: number of pipeline registers behind ID, EXE through WB inclusive; minimum 2.
- LOAD_STAGE, 2: first entry index whose result bus carries load data; 1 ≤ LOAD_STAGE ≤ DEPTH-1.
- SELW, max(1, $clog2(DEPTH)): forwarding select width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_src1 / id_src2  in  REG_W  source register indices.
- id_src1_used / id_src2_used  in  1  source is actually read; an immediate form clears id_src2_used.
- id_dest  in  REG_W  destination index.
- id_wb_en  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a load.
- br_flush  in  1  taken branch resolved in EXE.
- mem_req  in  1  MEM stage performs an access this cycle.
- mem_ready  in  1  memory completes the access this cycle.
- stall_id  out  1  hold PC and IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- if_flush  out  1  invalidate IF/ID.
- pipe_freeze  out  1  hold every pipeline register.
- ex_fw_sel1 / ex_fw_sel2  out  SELW  operand source for EXE: 0 = ID/EX value, k = result bus of entry k.
- perf_stall / perf_flush / perf_freeze  out  32  counters, present only with HAZARD_PERF_EN.

## Operation
- The shadow pipeline has DEPTH entries of {valid, dest, wb_en, is_load}.
  - Entry 0 is the instruction in EXE.
  - Entry DEPTH-1 is the instruction in WB.
- Match, per source:
  - Find the lowest-index entry k with valid & wb_en & dest==src & src!=0 & src_used.
  - Lowest index means youngest, so it wins over older matches.
- Load-use hazard: the matched entry has is_load and k < LOAD_STAGE-1.
- stall_id = load-use on either source & id_valid & !br_flush.
- idex_bubble = stall_id | br_flush | !id_valid.
- if_flush = br_flush.
- pipe_freeze = mem_req & !mem_ready.
- Advance, on a clock edge with !pipe_freeze:
  - entry[k+1] ← entry[k].
  - entry[0] ← idex_bubble ? invalid : {1, id_dest, id_wb_en, id_is_load}.
- Forwarding select for the entering instruction:
  - ex_fw_sel = k+1 when k+1 ≤ DEPTH-1.
  - Otherwise 0: the register file is write-first, so a WB producer needs no bypass.
  - No match or bubble gives 0.
- Priority: pipe_freeze > br_flush > load-use stall.
  - While frozen, all state and registered outputs hold. Combinational outputs still evaluate, but the datapath ignores them.
  - The datapath holds br_flush stable while frozen.
- Register 0 never causes a hazard or a forward.

## Timing
- stall_id, idex_bubble, if_flush, pipe_freeze: combinational, same cycle as the inputs.
- ex_fw_sel1/2: registered; valid during the cycle the instruction occupies EXE.
- Load-use stall length: LOAD_STAGE-1-k cycles. DEPTH=3, LOAD_STAGE=2 gives 1 cycle.
- Reset (async, any time, including mid-stall or mid-freeze):
  - All entries invalid.
  - ex_fw_sel1/2 = 0, counters = 0.
  - Combinational outputs follow from the empty state: 0 unless br_flush, !id_valid (idex_bubble=1) or mem_req & !mem_ready.
- Freeze of any length: no entry lost or duplicated; the pipeline resumes on the first cycle with mem_ready=1.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_stall counts cycles with stall_id & !pipe_freeze.
  - perf_flush counts cycles with br_flush & !pipe_freeze.
  - perf_freeze counts cycles with pipe_freeze.
  - All are 32-bit, saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the perf ports and counter logic are absent; all other behaviour is identical.

## Structure
- mips_pipe_pkg holds:
  - the shadow-entry struct;
  - the select encoding constant FW_SEL_REGFILE = 0;
  - the default DEPTH/LOAD_STAGE constants.
- One sub-module, pipe_src_match: per-source priority match returning {hit, k, is_load}, instantiated twice.

## Test plan
Parameters: DEPTH=3, LOAD_STAGE=2.
- ALU producer then consumer: add r3 then add r4,r3,r1 back-to-back → no stall; ex_fw_sel1=1 in the consumer's EXE cycle.
- Load-use: lw r5 then add r6,r5,r5 → stall_id=1 and idex_bubble=1 for exactly 1 cycle; then ex_fw_sel1=ex_fw_sel2=2.
- Youngest wins: r3 written by entries 0 and 1 → ex_fw_sel=1; producer in WB only → ex_fw_sel=0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles → pipe_freeze high 4 cycles; entries and ex_fw_sel unchanged; perf_freeze += 4.
- Flush during a load-use hazard: br_flush=1 → if_flush=1, stall_id=0, idex_bubble=1; perf_flush += 1.
- Register 0 and reset: src=r0 against a dest=r0 producer → no stall, sel 0. rst low mid-stall → all outputs clear immediately.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: shadow-pipeline entry type, forwarding-select encoding and default
//          pipeline geometry shared by pipe_hazard_ctrl and pipe_src_match.
// Ports:   none (package).
package mips_pipe_pkg;

  // Widest register index the shadow entry can hold; narrower indices are
  // zero-extended on entry and on comparison.
  localparam int REG_W_MAX = 8;

  localparam int DEFAULT_DEPTH      = 3;
  localparam int DEFAULT_LOAD_STAGE = 2;

  // Select value meaning "use the ID/EX operand read from the register file".
  localparam int FW_SEL_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dest;
    logic                 wb_en;
    logic                 is_load;
  } shadow_entry_t;

endpackage

// File: rtl/pipe_src_match.sv
// rtl/pipe_src_match.sv - youngest-producer match for one decode source operand
//
// Purpose: scans the shadow pipeline for the lowest-index (youngest) entry that
//          writes the given source register.
// Ports:
//   entries   in   DEPTH shadow entries, index 0 = EXE
//   src       in   source register index
//   src_used  in   source is actually read
//   hit       out  a producer was found
//   k         out  index of the youngest producer
//   is_load   out  that producer is a load
module pipe_src_match
  import mips_pipe_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int REG_W = 5,
  parameter int KW    = 2
) (
  input  shadow_entry_t    entries [DEPTH],
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  output logic             hit,
  output logic [KW-1:0]    k,
  output logic             is_load
);

  logic [REG_W_MAX-1:0] src_ext;
  assign src_ext = REG_W_MAX'(src);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    if (src_used && (src != '0)) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries[i].valid && entries[i].wb_en && (entries[i].dest == src_ext)) begin
          hit     = 1'b1;
          k       = KW'(i);
          is_load = entries[i].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, bubble, flush, freeze and forwarding control
//
// Purpose: tracks in-flight destinations in a DEPTH-entry shadow pipeline and
//          derives hazard controls plus registered EXE forwarding selects.
//          Optional macro HAZARD_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   id_valid                  decode holds a real instruction
//   id_src1/2, id_src1/2_used source indices and their use flags
//   id_dest, id_wb_en         destination and register-file write enable
//   id_is_load                decode instruction is a load
//   br_flush                  taken branch resolved in EXE
//   mem_req, mem_ready        MEM access in progress / completing
//   stall_id                  hold PC and IF/ID
//   idex_bubble               load a NOP into ID/EX
//   if_flush                  invalidate IF/ID
//   pipe_freeze               hold every pipeline register
//   ex_fw_sel1/2              EXE operand source, 0 = ID/EX, k = entry k bus
//   perf_stall/flush/freeze   event counters (HAZARD_PERF_EN only)
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int LOAD_STAGE = DEFAULT_LOAD_STAGE,
  parameter int SELW       = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_is_load,
  input  logic             br_flush,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_id,
  output logic             idex_bubble,
  output logic             if_flush,
  output logic             pipe_freeze,
  output logic [SELW-1:0]  ex_fw_sel1,
  output logic [SELW-1:0]  ex_fw_sel2
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush,
  output logic [31:0]      perf_freeze
`endif
);

  shadow_entry_t shadow_q [DEPTH];
  shadow_entry_t entry_in;

  logic            hit1, hit2;
  logic            ld1, ld2;
  logic [SELW-1:0] k1, k2;
  logic            load_use1, load_use2;
  logic [SELW-1:0] sel1_d, sel2_d;

  pipe_src_match #(.DEPTH(DEPTH), .REG_W(REG_W), .KW(SELW)) u_match1 (
    .entries  (shadow_q),
    .src      (id_src1),
    .src_used (id_src1_used),
    .hit      (hit1),
    .k        (k1),
    .is_load  (ld1)
  );

  pipe_src_match #(.DEPTH(DEPTH), .REG_W(REG_W), .KW(SELW)) u_match2 (
    .entries  (shadow_q),
    .src      (id_src2),
    .src_used (id_src2_used),
    .hit      (hit2),
    .k        (k2),
    .is_load  (ld2)
  );

  // A load's data only appears from entry LOAD_STAGE onward; a consumer entering
  // EXE next cycle sees the producer at k+1, so k must reach LOAD_STAGE-1.
  assign load_use1 = hit1 && ld1 && (int'(k1) < LOAD_STAGE - 1);
  assign load_use2 = hit2 && ld2 && (int'(k2) < LOAD_STAGE - 1);

  assign pipe_freeze = mem_req & ~mem_ready;
  assign if_flush    = br_flush;
  assign stall_id    = (load_use1 | load_use2) & id_valid & ~br_flush;
  assign idex_bubble = stall_id | br_flush | ~id_valid;

  always_comb begin
    entry_in = '0;
    if (!idex_bubble) begin
      entry_in.valid   = 1'b1;
      entry_in.dest    = REG_W_MAX'(id_dest);
      entry_in.wb_en   = id_wb_en;
      entry_in.is_load = id_is_load;
    end
  end

  // After the advance the producer sits one entry deeper. A producer that will
  // be in WB needs no bypass because the register file is write-first.
  always_comb begin
    sel1_d = SELW'(FW_SEL_REGFILE);
    sel2_d = SELW'(FW_SEL_REGFILE);
    if (!idex_bubble && hit1 && (int'(k1) <= DEPTH - 2)) begin
      sel1_d = k1 + SELW'(1);
    end
    if (!idex_bubble && hit2 && (int'(k2) <= DEPTH - 2)) begin
      sel2_d = k2 + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
      ex_fw_sel1 <= SELW'(FW_SEL_REGFILE);
      ex_fw_sel2 <= SELW'(FW_SEL_REGFILE);
    end else if (!pipe_freeze) begin
      shadow_q[0] <= entry_in;
      for (int i = 1; i < DEPTH; i++) begin
        shadow_q[i] <= shadow_q[i-1];
      end
      ex_fw_sel1 <= sel1_d;
      ex_fw_sel2 <= sel2_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall  <= '0;
      perf_flush  <= '0;
      perf_freeze <= '0;
    end else begin
      if (stall_id && !pipe_freeze && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (br_flush && !pipe_freeze && (perf_flush != '1)) begin
        perf_flush <= perf_flush + 32'd1;
      end
      if (pipe_freeze && (perf_freeze != '1)) begin
        perf_freeze <= perf_freeze + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl (DEPTH=3, LOAD_STAGE=2)
module tb_pipe_hazard_ctrl;

  localparam int D    = 3;
  localparam int LS   = 2;
  localparam int RW   = 5;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [RW-1:0]   id_src1, id_src2, id_dest;
  logic            id_src1_used, id_src2_used, id_wb_en, id_is_load;
  logic            br_flush, mem_req, mem_ready;
  logic            stall_id, idex_bubble, if_flush, pipe_freeze;
  logic [SELW-1:0] ex_fw_sel1, ex_fw_sel2;
`ifdef HAZARD_PERF_EN
  logic [31:0]     perf_stall, perf_flush, perf_freeze;
`endif

  pipe_hazard_ctrl #(.REG_W(RW), .DEPTH(D), .LOAD_STAGE(LS), .SELW(SELW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_is_load   (id_is_load),
    .br_flush     (br_flush),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .stall_id     (stall_id),
    .idex_bubble  (idex_bubble),
    .if_flush     (if_flush),
    .pipe_freeze  (pipe_freeze),
    .ex_fw_sel1   (ex_fw_sel1),
    .ex_fw_sel2   (ex_fw_sel2)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush),
    .perf_freeze  (perf_freeze)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stall, bubble, flush, freeze;
    int sel1, sel2;
    int unsigned pstall, pflush, pfreeze;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Reference model: in-flight instructions, index 0 = youngest (in EXE).
  bit          m_valid [D];
  int          m_dest  [D];
  bit          m_wb    [D];
  bit          m_ld    [D];
  int          m_sel1, m_sel2;
  int unsigned m_pstall, m_pflush, m_pfreeze;

  // Per-cycle control knobs used by the directed sequences.
  bit c_rst = 1'b1, c_br = 1'b0, c_mq = 1'b0, c_mr = 1'b1;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0; m_dest[i] = 0; m_wb[i] = 0; m_ld[i] = 0;
    end
    m_sel1 = 0; m_sel2 = 0;
    m_pstall = 0; m_pflush = 0; m_pfreeze = 0;
  endfunction

  function automatic int find_producer(input int src, input bit used, output bit is_ld);
    is_ld = 0;
    if (!used || src == 0) return -1;
    for (int i = 0; i < D; i++) begin
      if (m_valid[i] && m_wb[i] && m_dest[i] == src) begin
        is_ld = m_ld[i];
        return i;
      end
    end
    return -1;
  endfunction

  function automatic int sel_for(input int k);
    if (k < 0) return 0;
    return (k + 1 <= D - 1) ? k + 1 : 0;
  endfunction

  task automatic step(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                      input int d, input bit wb, input bit ld);
    exp_t e;
    int   k1, k2;
    bit   l1, l2, lu;
    @(negedge clk);
    rst = c_rst; id_valid = v;
    id_src1 = RW'(s1); id_src1_used = u1;
    id_src2 = RW'(s2); id_src2_used = u2;
    id_dest = RW'(d); id_wb_en = wb; id_is_load = ld;
    br_flush = c_br; mem_req = c_mq; mem_ready = c_mr;
    if (!c_rst) model_reset();
    k1 = find_producer(s1, u1, l1);
    k2 = find_producer(s2, u2, l2);
    lu = (k1 >= 0 && l1 && k1 < LS - 1) || (k2 >= 0 && l2 && k2 < LS - 1);
    e.stall   = lu && v && !c_br;
    e.bubble  = e.stall || c_br || !v;
    e.flush   = c_br;
    e.freeze  = c_mq && !c_mr;
    e.sel1    = m_sel1;
    e.sel2    = m_sel2;
    e.pstall  = m_pstall;
    e.pflush  = m_pflush;
    e.pfreeze = m_pfreeze;
    exp_q.push_back(e);
    if (c_rst) begin
      if (e.stall && !e.freeze && m_pstall != 32'hFFFF_FFFF) m_pstall++;
      if (c_br && !e.freeze && m_pflush != 32'hFFFF_FFFF) m_pflush++;
      if (e.freeze && m_pfreeze != 32'hFFFF_FFFF) m_pfreeze++;
      if (!e.freeze) begin
        m_sel1 = e.bubble ? 0 : sel_for(k1);
        m_sel2 = e.bubble ? 0 : sel_for(k2);
        for (int i = D - 1; i > 0; i--) begin
          m_valid[i] = m_valid[i-1]; m_dest[i] = m_dest[i-1];
          m_wb[i] = m_wb[i-1]; m_ld[i] = m_ld[i-1];
        end
        m_valid[0] = !e.bubble; m_dest[0] = d; m_wb[0] = wb; m_ld[0] = ld;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents its controls every cycle; pop and compare.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_id",    stall_id,    e.stall);
        check("idex_bubble", idex_bubble, e.bubble);
        check("if_flush",    if_flush,    e.flush);
        check("pipe_freeze", pipe_freeze, e.freeze);
        check("ex_fw_sel1",  ex_fw_sel1,  e.sel1);
        check("ex_fw_sel2",  ex_fw_sel2,  e.sel2);
`ifdef HAZARD_PERF_EN
        check("perf_stall",  perf_stall,  e.pstall);
        check("perf_flush",  perf_flush,  e.pflush);
        check("perf_freeze", perf_freeze, e.pfreeze);
`endif
      end
    end
  end

  initial begin
    bit prev_freeze = 0;
    model_reset();
    rst = 1'b0; id_valid = 0; id_src1 = '0; id_src2 = '0; id_src1_used = 0; id_src2_used = 0;
    id_dest = '0; id_wb_en = 0; id_is_load = 0; br_flush = 0; mem_req = 0; mem_ready = 1;

    // Reset state.
    c_rst = 0; idle(); idle(); c_rst = 1;
    idle();

    // ALU producer then consumer: add r3,r1,r2 ; add r4,r3,r1.
    step(1, 1, 1, 2, 1, 3, 1, 0);
    step(1, 3, 1, 1, 1, 4, 1, 0);
    idle(); idle(); idle();

    // Load-use: lw r5 ; add r6,r5,r5 (held through the one-cycle stall).
    step(1, 1, 1, 0, 0, 5, 1, 1);
    step(1, 5, 1, 5, 1, 6, 1, 0);
    step(1, 5, 1, 5, 1, 6, 1, 0);
    idle(); idle(); idle();

    // Youngest wins, then producer in WB only.
    step(1, 1, 1, 2, 1, 3, 1, 0);
    step(1, 2, 1, 1, 1, 3, 1, 0);
    step(1, 3, 1, 3, 1, 7, 1, 0);
    idle();
    step(1, 1, 1, 2, 1, 3, 1, 0);
    idle(); idle();
    step(1, 3, 1, 3, 1, 8, 1, 0);
    idle(); idle(); idle();

    // Memory wait for 4 cycles with a forwarded consumer in flight.
    step(1, 1, 1, 2, 1, 9, 1, 0);
    c_mq = 1; c_mr = 0;
    step(1, 9, 1, 1, 1, 10, 1, 0);
    repeat (3) step(1, 9, 1, 1, 1, 10, 1, 0);
    c_mr = 1;
    step(1, 9, 1, 1, 1, 10, 1, 0);
    c_mq = 0;
    idle(); idle(); idle();

    // Flush during a load-use hazard.
    step(1, 1, 1, 0, 0, 5, 1, 1);
    c_br = 1;
    step(1, 5, 1, 5, 1, 6, 1, 0);
    c_br = 0;
    idle(); idle(); idle();

    // Register 0 never matches.
    step(1, 1, 1, 0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1, 4, 1, 0);
    idle(); idle(); idle();

    // Reset asserted in the middle of a load-use stall.
    step(1, 1, 1, 0, 0, 5, 1, 1);
    c_rst = 0;
    step(1, 5, 1, 5, 1, 6, 1, 0);
    c_rst = 1;
    step(1, 5, 1, 5, 1, 6, 1, 0);
    idle(); idle();

    // Randomized traffic over a small register set so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      c_rst = ($urandom_range(0, 199) != 0);
      if (!prev_freeze) c_br = ($urandom_range(0, 9) == 0);
      c_mq = ($urandom_range(0, 9) < 3);
      c_mr = ($urandom_range(0, 9) < 6);
      prev_freeze = c_rst && c_mq && !c_mr;
      step($urandom_range(0, 99) < 85,
           $urandom_range(0, 3), $urandom_range(0, 9) < 8,
           $urandom_range(0, 3), $urandom_range(0, 9) < 6,
           $urandom_range(0, 3), $urandom_range(0, 9) < 8, $urandom_range(0, 2) == 0);
    end
    c_rst = 1; c_br = 0; c_mq = 0; c_mr = 1;
    idle();

    @(negedge clk);
    #5;
    done = 1'b1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
